memory_unit: RTL
================

# memory_unit

- Executes load/store requests dispatched by the reservation station's memory slots (entries 3–5).
- Takes one request at a time over the `memory_*` dispatch bus and holds `memory_busy` while working.
- Accesses a byte-wide synchronous RAM sequentially, little-endian.
- Broadcasts a one-cycle result (data + tag) that feeds the reservation station's `memory_data`/`memory_des_in` wake-up inputs.

## Interface
Parameters: none.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- memory_op  in  6  opcode; LB=18, LH=19, LW=20, LBU=21, LHU=22, SB=23, SH=24, SW=25.
- memory_value1  in  32  base operand.
- memory_value2  in  32  store data.
- memory_imm  in  32  address offset.
- memory_des  in  3  destination tag; 0 = no request this cycle.
- memory_busy  out  1  registered; high while a request is in progress.
- result_data  out  32  load result; 0 for stores.
- result_des  out  3  result tag pulse; 0 = no broadcast.
- mem_a  out  32  RAM byte address.
- mem_dout  out  8  RAM write byte.
- mem_wr  out  1  RAM write enable.
- mem_din  in  8  RAM read byte; valid the cycle after the address edge (1-cycle read latency).

## Operation
Accept rule:
- Accept happens at a posedge when state is IDLE, `memory_des != 0` and `memory_op` is in 18..25.
- On accept, latch `addr = memory_value1 + memory_imm` (32-bit, modulo 2^32), `memory_value2`, the opcode and the tag.
- A nonzero tag with an opcode outside 18..25 is ignored: no accept, no broadcast.

Byte count n:
- n = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Byte k uses address addr+k, wrapping at 2^32.
- No alignment check; misaligned accesses are legal.

States:
- IDLE → ACCESS on accept.
- ACCESS issues bytes 0..n-1.
  - Stores go to IDLE after the last byte, with the broadcast.
  - Loads go to DRAIN.
- DRAIN captures the final read byte, then goes to IDLE with the broadcast.

Stores:
- Byte k is `value2[8k+7:8k]`.
- `mem_wr` is high only while a store byte is presented.

Loads:
- Byte k is captured into bits [8k+7:8k].
- LB and LH sign-extend from bit 7 and bit 15 respectively.
- LBU and LHU zero-extend.

`memory_busy`:
- Set at the accept edge; cleared at the broadcast edge.
- A new request can therefore be accepted at the edge immediately after the broadcast edge.

Reset values (async, active-high rst):
- `memory_busy = 0`, `result_data = 0`, `result_des = 0`, `mem_a = 0`, `mem_dout = 0`, `mem_wr = 0`.
- State returns to IDLE.
- Reset mid-store leaves bytes already written in RAM; there is no rollback and no broadcast.

## Timing
Edges are numbered E0 = accept edge.
- mem_a/mem_wr/mem_dout for byte k are registered at Ek (k = 0..n-1), so byte 0 is presented in the cycle after E0.
- Loads: byte k is captured from `mem_din` at E(k+2). `result_des`/`result_data` are registered at E(n+1), and `memory_busy` falls at E(n+1). Latency is LB 2, LH 3, LW 5 edges.
- Stores: the last byte is written by the RAM at En. The broadcast is registered at En with `result_data = 0`, and `memory_busy` falls at En.
- `result_des` is nonzero for exactly one cycle and is 0 at all other times.
- At the broadcast edge `mem_wr = 0` and `mem_a` holds its last value.
- Inputs are ignored at every edge where state ≠ IDLE, including the broadcast edge.

## Configuration
Macro `MEMORY_UNIT_STALL_EN`.

Defined:
- Adds port `mem_stall in 1`.
- At any edge with `mem_stall = 1` in ACCESS or DRAIN: no byte index advances, no capture occurs, and `mem_wr` is forced to 0.
- Address, store data and partial result hold.
- Latency grows by the number of stalled edges.
- Stall has no effect in IDLE.

Undefined:
- No port; behaviour is exactly as specified above.

## Test plan
- **LW:** value1=0x100, imm=4, RAM[0x104..0x107]=78,56,34,12, des=3 → mem_a steps 0x104..0x107; result_data=0x12345678, result_des=3 one cycle at E5; memory_busy high E0..E4.
- **LB/LBU/LHU extension:** LB at a byte holding 0x80 → 0xFFFFFF80; LBU same address → 0x00000080; LHU with bytes 01,80 → 0x00008001.
- **SH:** value1=0x1FE, imm=2, value2=0xABCD1234, des=5 → writes 0x34@0x200, 0x12@0x201 (mem_wr high 2 cycles); result_des=5, result_data=0 at E2.
- **Back-to-back and ignore:** second request held on the bus throughout the first → accepted at the edge after the broadcast; op=5 with des=2 in IDLE → no accept, busy stays 0.
- **Wrap and reset:** SW at addr 0xFFFFFFFE → bytes at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Reset asserted after 2 bytes of a SW → all outputs 0 immediately, no broadcast, next request accepted normally.
- **Stall (`MEMORY_UNIT_STALL_EN`):** LW with mem_stall high for 3 edges mid-access → correct data, broadcast at E8.

Source files
------------

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - sequential little-endian load/store unit over a byte-wide synchronous RAM
// Optional feature macro: MEMORY_UNIT_STALL_EN (adds mem_stall, freezing ACCESS/DRAIN while high).
module memory_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  memory_op,
    input  logic [31:0] memory_value1,
    input  logic [31:0] memory_value2,
    input  logic [31:0] memory_imm,
    input  logic [2:0]  memory_des,
    output logic        memory_busy,
    output logic [31:0] result_data,
    output logic [2:0]  result_des,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din
`ifdef MEMORY_UNIT_STALL_EN
    ,
    input  logic        mem_stall
`endif
);

    localparam logic [5:0] OP_LB  = 6'd18;
    localparam logic [5:0] OP_LH  = 6'd19;
    localparam logic [5:0] OP_LW  = 6'd20;
    localparam logic [5:0] OP_LBU = 6'd21;
    localparam logic [5:0] OP_LHU = 6'd22;
    localparam logic [5:0] OP_SB  = 6'd23;
    localparam logic [5:0] OP_SH  = 6'd24;
    localparam logic [5:0] OP_SW  = 6'd25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic logic valid_op(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op >= OP_SB;
    endfunction

    function automatic logic [2:0] byte_count(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: byte_count = 3'd1;
            OP_LH, OP_LHU, OP_SH: byte_count = 3'd2;
            OP_LW, OP_SW:         byte_count = 3'd4;
            default:              byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
        case (op)
            OP_LB:   extend = {{24{w[7]}}, w[7:0]};
            OP_LH:   extend = {{16{w[15]}}, w[15:0]};
            OP_LBU:  extend = {24'd0, w[7:0]};
            OP_LHU:  extend = {16'd0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [5:0]  op_q, op_d;
    logic [2:0]  des_q, des_d;
    logic [31:0] rdata_q, rdata_d;

    logic        busy_d;
    logic [31:0] res_data_d;
    logic [2:0]  res_des_d;
    logic [31:0] mem_a_d;
    logic [7:0]  mem_dout_d;
    logic        mem_wr_d;

    logic        stall;
    logic        accept;
    logic [2:0]  n_q;
    logic        store_q;
    logic [1:0]  cap_sel;
    logic [1:0]  last_sel;
    logic [31:0] load_word;
    logic [31:0] req_addr;

`ifdef MEMORY_UNIT_STALL_EN
    assign stall = mem_stall;
`else
    assign stall = 1'b0;
`endif

    assign req_addr = memory_value1 + memory_imm;
    assign accept   = (state_q == IDLE) && (memory_des != 3'd0) && valid_op(memory_op);
    assign n_q      = byte_count(op_q);
    assign store_q  = is_store(op_q);
    // Read data lags the presented address by two edges; 2-bit wrap maps idx 4 to byte 2.
    assign cap_sel  = idx_q[1:0] - 2'd2;
    assign last_sel = n_q[1:0] - 2'd1;

    always_comb begin
        load_word = rdata_q;
        load_word[{last_sel, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!stall && (idx_q == n_q)) begin
                    state_d = store_q ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        des_d      = des_q;
        rdata_d    = rdata_q;
        busy_d     = memory_busy;
        res_data_d = result_data;
        res_des_d  = 3'd0;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        mem_wr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = req_addr;
                    wdata_d    = memory_value2;
                    op_d       = memory_op;
                    des_d      = memory_des;
                    rdata_d    = 32'd0;
                    idx_d      = 3'd1;
                    busy_d     = 1'b1;
                    mem_a_d    = req_addr;
                    mem_dout_d = memory_value2[7:0];
                    mem_wr_d   = is_store(memory_op);
                end
            end
            ACCESS: begin
                if (!stall) begin
                    if (idx_q < n_q) begin
                        mem_a_d    = addr_q + {29'd0, idx_q};
                        mem_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = store_q;
                        idx_d      = idx_q + 3'd1;
                    end
                    if (!store_q && (idx_q >= 3'd2)) begin
                        rdata_d[{cap_sel, 3'b000} +: 8] = mem_din;
                    end
                    if (store_q && (idx_q == n_q)) begin
                        res_des_d  = des_q;
                        res_data_d = 32'd0;
                        busy_d     = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    rdata_d    = load_word;
                    res_data_d = extend(op_q, load_word);
                    res_des_d  = des_q;
                    busy_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            op_q        <= 6'd0;
            des_q       <= 3'd0;
            rdata_q     <= 32'd0;
            memory_busy <= 1'b0;
            result_data <= 32'd0;
            result_des  <= 3'd0;
            mem_a       <= 32'd0;
            mem_dout    <= 8'd0;
            mem_wr      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            des_q       <= des_d;
            rdata_q     <= rdata_d;
            memory_busy <= busy_d;
            result_data <= res_data_d;
            result_des  <= res_des_d;
            mem_a       <= mem_a_d;
            mem_dout    <= mem_dout_d;
            mem_wr      <= mem_wr_d;
        end
    end

endmodule
